// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment scanner for an hour value (00..23).
//
// Parameters:
//   SCAN_DIV     clock cycles per digit slot (>= 2)
//   BLINK_FRAMES frames per blink half-period (>= 1)
//
// Ports:
//   clk        clock, all state updates on posedge
//   n_rst      asynchronous active-low reset
//   tens_place BCD tens digit (sampled once per frame)
//   ones_place BCD ones digit (sampled once per frame)
//   blank_lz   1 = suppress a leading zero in the tens digit
//   blink      1 = flash the display
//   seg        active-low segments, seg[0]=a .. seg[6]=g
//   dig        active-low digit enables, dig[0]=ones, dig[1]=tens
//   frame      one-cycle pulse in the cycle a new snapshot is taken
//
// All outputs are registers computed from the state (cnt, sel, shadow, phase) of the
// previous cycle, so the displayed slot boundaries trail the prescaler by one cycle.
module seg7_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tens_place,
  input  logic [3:0] ones_place,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       frame
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned FrW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SegDash = 7'h3F;
  localparam logic [6:0] SegOff  = 7'h7F;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_q;
  logic [1:0]      tens_q;
  logic [3:0]      ones_q;
  logic            phase_q, phase_d;
  logic [FrW-1:0]  fcnt_q, fcnt_d;

  logic       tick;
  logic       snap;
  logic       over;
  logic       tens_dash;
  logic       ones_dash;
  logic       tens_blank;
  logic [6:0] seg_d;
  logic [1:0] dig_sel;
  logic [1:0] dig_d;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] c;
    case (v)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = SegDash;
    endcase
    return c;
  endfunction

  assign tick = (cnt_q == CntW'(SCAN_DIV - 1));
  // Snapshot on the tick that wraps sel from tens (1) back to ones (0).
  assign snap = tick & sel_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Blink phase: counts frame pulses while blink is held, cleared as soon as it drops.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!blink) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (snap) begin
      if (fcnt_q == FrW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Digit decode from the shadow registers only.
  always_comb begin
    over       = (tens_q == 2'd2) && (ones_q >= 4'd4) && (ones_q <= 4'd9);
    ones_dash  = (ones_q > 4'd9) || over;
    tens_dash  = (tens_q == 2'd3) || over;
    tens_blank = blank_lz && (tens_q == 2'd0);

    if (sel_q) begin
      if (tens_blank) begin
        seg_d   = SegOff;
        dig_sel = 2'b11;
      end else begin
        seg_d   = tens_dash ? SegDash : seg_code({2'b00, tens_q});
        dig_sel = 2'b01;
      end
    end else begin
      seg_d   = ones_dash ? SegDash : seg_code(ones_q);
      dig_sel = 2'b10;
    end

    // Ghost guard on the first cycle of each slot, and dark half of the blink.
    if ((cnt_q == '0) || (blink && phase_q)) begin
      dig_d = 2'b11;
    end else begin
      dig_d = dig_sel;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      tens_q  <= 2'd0;
      ones_q  <= 4'd0;
      phase_q <= 1'b0;
      fcnt_q  <= '0;
      seg     <= SegOff;
      dig     <= 2'b11;
      frame   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      if (tick) begin
        sel_q <= ~sel_q;
      end
      if (snap) begin
        tens_q <= tens_place;
        ones_q <= ones_place;
      end
      seg   <= seg_d;
      dig   <= dig_d;
      frame <= snap;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (SCAN_DIV=4, BLINK_FRAMES=2).
// The driver applies inputs on the falling edge and pushes the output expected after the
// next rising edge; the monitor pops and compares 1 ns after every rising edge.
// The reference model works from the count of clock edges since reset release.
module tb_seg7_scan;

  localparam int N  = 4;
  localparam int BF = 2;

  logic       clk;
  logic       n_rst;
  logic [1:0] tens_place;
  logic [3:0] ones_place;
  logic       blank_lz;
  logic       blink;
  logic [6:0] seg;
  logic [1:0] dig;
  logic       frame;

  seg7_scan #(
    .SCAN_DIV    (N),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tens_place(tens_place),
    .ones_place(ones_place),
    .blank_lz  (blank_lz),
    .blink     (blink),
    .seg       (seg),
    .dig       (dig),
    .frame     (frame)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] dig;
    logic       frame;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [6:0] tbl[10];

  // Reference model state: edges since release, displayed value, frames seen under blink.
  int         e;
  int         sh_t;
  int         sh_o;
  int         seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_tests++;
      if (seg !== x.seg || dig !== x.dig || frame !== x.frame) begin
        n_fail++;
        $display("FAIL out t=%0t: got seg=%h dig=%b frame=%b, required seg=%h dig=%b frame=%b",
                 $time, seg, dig, frame, x.seg, x.dig, x.frame);
      end
    end
  end

  function automatic bit phase_now();
    return ((seen / BF) % 2) == 1;
  endfunction

  task automatic model_reset();
    e    = 0;
    sh_t = 0;
    sh_o = 0;
    seen = 0;
  endtask

  task automatic cycle(input logic rst, input logic [1:0] t, input logic [3:0] o,
                       input logic bl, input logic bk);
    exp_t x;
    int   cnt;
    int   sel;
    bit   ones_bad;
    bit   tens_bad;
    bit   both_bad;
    @(negedge clk);
    n_rst      = rst;
    tens_place = t;
    ones_place = o;
    blank_lz   = bl;
    blink      = bk;
    if (!rst) begin
      model_reset();
      x = '{seg: 7'h7F, dig: 2'b11, frame: 1'b0};
    end else begin
      cnt      = e % N;
      sel      = (e / N) % 2;
      ones_bad = sh_o > 9;
      tens_bad = sh_t > 2;
      both_bad = !ones_bad && !tens_bad && (sh_t * 10 + sh_o > 23);
      if (sel == 0) begin
        x.seg = (ones_bad || both_bad) ? 7'h3F : tbl[sh_o];
        x.dig = 2'b10;
      end else if (bl && sh_t == 0) begin
        x.seg = 7'h7F;
        x.dig = 2'b11;
      end else begin
        x.seg = (tens_bad || both_bad) ? 7'h3F : tbl[sh_t];
        x.dig = 2'b01;
      end
      if (cnt == 0 || (bk && phase_now())) x.dig = 2'b11;
      x.frame = ((e + 1) % (2 * N)) == 0;
      e++;
      if (!bk) begin
        seen = 0;
      end else if (e % (2 * N) == 0) begin
        seen++;
      end
      if (e % (2 * N) == 0) begin
        sh_t = int'(t);
        sh_o = int'(o);
      end
    end
    q.push_back(x);
  endtask

  task automatic run(input int n, input logic [1:0] t, input logic [3:0] o,
                     input logic bl, input logic bk);
    for (int i = 0; i < n; i++) cycle(1'b1, t, o, bl, bk);
  endtask

  // Reset pulled low between clock edges must clear the outputs before the next edge.
  task automatic async_rst_check();
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (seg !== 7'h7F || dig !== 2'b11 || frame !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got seg=%h dig=%b frame=%b, required seg=7f dig=11 frame=0",
               seg, dig, frame);
    end
  endtask

  initial begin
    int guard;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    n_rst      = 1'b0;
    tens_place = 2'd0;
    ones_place = 4'd0;
    blank_lz   = 1'b0;
    blink      = 1'b0;
    model_reset();

    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

    // 17 with no blanking, then 05 with leading-zero blanking.
    run(24, 2'd1, 4'd7, 1'b0, 1'b0);
    run(24, 2'd0, 4'd5, 1'b1, 1'b0);
    // Invalid combinations.
    run(16, 2'd2, 4'd5, 1'b0, 1'b0);
    run(16, 2'd1, 4'd12, 1'b0, 1'b0);
    run(16, 2'd3, 4'd4, 1'b0, 1'b0);

    // Change 17 -> 23 during the tens slot.
    run(16, 2'd1, 4'd7, 1'b0, 1'b0);
    guard = 0;
    while (!((e / N) % 2 == 1 && e % N == 1) && guard < 16) begin
      cycle(1'b1, 2'd1, 4'd7, 1'b0, 1'b0);
      guard++;
    end
    run(24, 2'd2, 4'd3, 1'b0, 1'b0);

    // Blink, then drop blink during a dark phase.
    run(48, 2'd1, 4'd7, 1'b0, 1'b1);
    guard = 0;
    while (!phase_now() && guard < 64) begin
      cycle(1'b1, 2'd1, 4'd7, 1'b0, 1'b1);
      guard++;
    end
    run(3, 2'd1, 4'd7, 1'b0, 1'b1);
    run(16, 2'd1, 4'd7, 1'b0, 1'b0);

    // Reset mid-frame, then resume.
    run(5, 2'd2, 4'd1, 1'b0, 1'b0);
    async_rst_check();
    for (int i = 0; i < 2; i++) cycle(1'b0, 2'd2, 4'd1, 1'b0, 1'b0);
    run(20, 2'd2, 4'd1, 1'b0, 1'b0);

    // Randomized traffic with occasional resets and blink toggles.
    begin
      logic bk;
      bk = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(19) == 0) bk = ~bk;
        cycle(($urandom_range(79) != 0), 2'($urandom_range(3)), 4'($urandom_range(15)),
              1'($urandom_range(1)), bk);
      end
    end

    @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameters SHALL be:
- SCAN_DIV, default 1000, clock cycles per digit slot, legal range >= 2.
- BLINK_FRAMES, default 64, frames per blink half-period, legal range >= 1.

REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, all state updates on posedge.
- n_rst  in  1  asynchronous reset, active-low.
- tens_place  in  2  BCD tens digit of the hour value.
- ones_place  in  4  BCD ones digit of the hour value.
- blank_lz  in  1  1 = suppress leading zero in the tens digit.
- blink  in  1  1 = flash the display.
- seg  out  7  active-low segments; seg[0]=a ... seg[6]=g.
- dig  out  2  active-low digit enables; dig[0]=ones, dig[1]=tens.
- frame  out  1  one-cycle pulse, high when a new snapshot is taken.

Function
REQ-003 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; "tick" = cycle with cnt==SCAN_DIV-1.
REQ-004 Digit select sel SHALL toggle on each tick (0=ones, 1=tens); a frame = two slots, 2*SCAN_DIV cycles.
REQ-005 On the tick that takes sel from 1 to 0, shadow registers SHALL latch tens_place/ones_place; frame SHALL be 1 in the following cycle only.
REQ-006 Displayed digits SHALL come only from the shadow registers; input changes mid-frame SHALL NOT alter seg until the next snapshot.
REQ-007 Ghost guard: in every cycle with cnt==0, dig SHALL be 2'b11.
REQ-008 In other cycles, dig SHALL enable only the digit selected by sel, unless blanked per REQ-011/REQ-012.
REQ-009 seg SHALL show the selected shadow digit using these active-low codes:
- 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19.
- 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
- '-'=0x3F, off=0x7F.
REQ-010 Invalid value handling SHALL be:
- ones 10..15 shows '-' on ones; tens 3 shows '-' on tens.
- Any pair >23 (tens 2 with ones 4..9) shows '-' on both digits.
REQ-011 When blank_lz=1 and shadow tens==0, the tens slot SHALL drive seg=0x7F and dig=2'b11; the ones digit is unaffected.
REQ-012 Blink behaviour SHALL be:
- A blink phase flag toggles every BLINK_FRAMES frame pulses while blink=1.
- While blink=1 and phase=1, dig SHALL be 2'b11.
- blink=0 SHALL clear the phase and its frame counter within one cycle.
REQ-013 seg, dig and frame SHALL be driven from registers, with no combinational path from any input to any output.
REQ-014 Outputs SHALL have a fixed latency of one cycle from the internal state (cnt, sel, shadow, phase) that selects them.

Reset
REQ-015 n_rst=0 SHALL immediately, without waiting for clk, force the following, and hold them while n_rst=0:
- cnt=0, sel=0, shadow=0, blink phase and frame counter=0.
- seg=0x7F, dig=2'b11, frame=0.
REQ-016 After n_rst rises, the first tick SHALL occur SCAN_DIV cycles later.
REQ-017 First snapshot: the first frame pulse follows the first 1->0 sel transition; until then the shadow value 0 is displayed (subject to blank_lz).
REQ-018 Reset asserted mid-frame SHALL discard the in-progress frame, with no partial snapshot.

Verification
REQ-019 The bench SHALL cover these directed scenarios, all with SCAN_DIV=4 and BLINK_FRAMES=2:
- Reset mid-scan: n_rst low between clocks -> seg=0x7F, dig=2'b11, frame=0 before the next edge.
- tens=1, ones=7, blank_lz=0 -> ones slot seg=0x78, dig=2'b10; tens slot seg=0x79, dig=2'b01; dig=2'b11 when cnt==0; frame every 8 cycles.
- blank_lz=1, tens=0, ones=5 -> tens slot seg=0x7F, dig=2'b11; ones slot seg=0x12.
- Invalid values: tens=2, ones=5 -> both slots seg=0x3F. tens=1, ones=12 -> ones 0x3F, tens 0x79.
- Change inputs 0x1_7 -> 0x2_3 during the tens slot -> seg keeps showing 17 until the cycle after the next frame pulse, then shows 23.
- blink=1 -> dig=2'b11 for 2 frames, then normal for 2 frames, repeating. blink=0 during a dark phase -> dig normal from the next non-guard cycle.
